// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its neighbours.
// Contents:
//   - datapath widths (XLEN, OP_W) and the fetch buffer depth
//   - primary opcode constants seen by the main control decoder
//   - NOP_WORD, the all-zero instruction word
//   - fetchState_t, the fetch sequencer states
package cpu_pkg;

   localparam int XLEN       = 32;
   localparam int OP_W       = 6;
   localparam int FIFO_DEPTH = 2;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetchState_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {pc, instr} pairs for the fetch stage.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, wrData    enqueue wrData at the tail (ignored when full)
//   pop             dequeue the head (ignored when empty)
//   flush           discard every entry; wins over push and pop
//   rdData          head entry, driven 0 when empty
//   count           number of valid entries (0..2)
//   empty, full     occupancy flags
module fetch_fifo #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wrData,
   output logic [WIDTH-1:0] rdData,
   output logic [1:0]       count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [0:1];
   logic             wrPtr;
   logic             rdPtr;
   logic [1:0]       countR;
   logic             pushOk;
   logic             popOk;

   assign empty  = (countR == 2'd0);
   assign full   = (countR == 2'd2);
   assign count  = countR;
   assign pushOk = push && !full;
   assign popOk  = pop && !empty;
   assign rdData = empty ? {WIDTH{1'b0}} : mem[rdPtr];

   // Pointer and occupancy tracking; flush returns to the empty state.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wrPtr  <= 1'b0;
         rdPtr  <= 1'b0;
         countR <= 2'd0;
      end else begin
         if (pushOk) wrPtr <= ~wrPtr;
         if (popOk)  rdPtr <= ~rdPtr;
         case ({pushOk, popOk})
            2'b10:   countR <= countR + 2'd1;
            2'b01:   countR <= countR - 2'd1;
            default: countR <= countR;
         endcase
      end
   end

   // Entry storage; cleared on reset so the buffer never holds X.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= {WIDTH{1'b0}};
         mem[1] <= {WIDTH{1'b0}};
      end else if (pushOk && !flush) begin
         mem[wrPtr] <= wrData;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the main control decoder.
// Keeps the PC, issues one outstanding word read at a time, buffers returned
// words in a two-entry FIFO and presents {instr_pc, instr, op} with
// valid/ready. A redirect from branch/jump resolution flushes everything in
// flight and restarts fetch at the new (word-aligned) address.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imem_req/addr/ready         read request channel to instruction memory
//   imem_rvalid/rdata           read response channel
//   redirect_valid/pc           taken branch/jump pulse and target
//   instr_valid/ready           handshake to decode
//   instr, instr_pc, op         head instruction, its address, its opcode
// Optional build macro IFETCH_PERF_EN adds perf_fetched (FIFO pushes) and
// perf_redirects (redirect pulses) counters.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [5:0]  op
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_redirects
`endif
);

   fetchState_t stateR;
   fetchState_t stateNext;
   logic [31:0] fetchPcR;
   logic [31:0] fetchPcNext;
   logic [31:0] advPc;
   logic [31:0] reqPcR;
   logic [31:0] reqPcNext;
   logic        dropR;
   logic        dropNext;
   logic        reqGo;
   logic        outstanding;
   logic [1:0]  inFlight;
   logic        fifoPush;
   logic        fifoPop;
   logic [1:0]  fifoCount;
   logic        fifoEmpty;
   logic        fifoFull;
   logic [63:0] headEntry;

   // A request still counts against buffer space until its data returns.
   assign outstanding = (stateR == WAIT);
   assign inFlight    = fifoCount + {1'b0, outstanding};

   assign imem_req    = reqGo;
   assign imem_addr   = fetchPcR;
   assign instr_valid = !fifoEmpty;
   assign instr_pc    = headEntry[63:32];
   assign instr       = headEntry[31:0];
   assign op          = headEntry[31:26];

   // A redirect cycle must not retire the head: the flush supersedes it.
   assign fifoPop = !fifoEmpty && instr_ready && !redirect_valid;

   // Fetch sequencer: next state, request gating, PC advance and drop flag.
   always_comb begin
      stateNext = stateR;
      advPc     = fetchPcR;
      reqPcNext = reqPcR;
      dropNext  = dropR;
      reqGo     = 1'b0;
      fifoPush  = 1'b0;
      case (stateR)
         IDLE: begin
            stateNext = REQ;
         end
         REQ: begin
            if (!redirect_valid && !fifoFull && (inFlight < 2'd2)) begin
               reqGo = 1'b1;
            end else begin
               reqGo = 1'b0;
            end
            if (reqGo && imem_ready) begin
               advPc     = fetchPcR + 32'd4;
               reqPcNext = fetchPcR;
               stateNext = WAIT;
            end else begin
               stateNext = REQ;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               // Stale data (pre-redirect request) is swallowed here.
               fifoPush  = !dropR && !redirect_valid;
               dropNext  = 1'b0;
               stateNext = REQ;
            end else if (redirect_valid) begin
               // Response still owed to memory: remember to discard it.
               dropNext  = 1'b1;
               stateNext = WAIT;
            end else begin
               stateNext = WAIT;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      if (redirect_valid) begin
         fetchPcNext = redirect_pc & ~32'h0000_0003;
      end else begin
         fetchPcNext = advPc;
      end
   end

   // Sequencer state, fetch PC, address of the outstanding request, drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateR   <= IDLE;
         fetchPcR <= RESET_PC & ~32'h0000_0003;
         reqPcR   <= 32'h0000_0000;
         dropR    <= 1'b0;
      end else begin
         stateR   <= stateNext;
         fetchPcR <= fetchPcNext;
         reqPcR   <= reqPcNext;
         dropR    <= dropNext;
      end
   end

   fetch_fifo #(.WIDTH(64)) uFifo (
      .clk    (clk),
      .rst    (rst),
      .push   (fifoPush),
      .pop    (fifoPop),
      .flush  (redirect_valid),
      .wrData ({reqPcR, imem_rdata}),
      .rdData (headEntry),
      .count  (fifoCount),
      .empty  (fifoEmpty),
      .full   (fifoFull)
   );

`ifdef IFETCH_PERF_EN
   // Free-running event counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched   <= 32'd0;
         perf_redirects <= 32'd0;
      end else begin
         if (fifoPush)       perf_fetched   <= perf_fetched + 32'd1;
         if (redirect_valid) perf_redirects <= perf_redirects + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations plus a queue-based reference model compared every cycle.
module tb_instr_fetch;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [5:0]  op;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_redirects;
`endif

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc), .op(op)
`ifdef IFETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`endif
   );

   int vectors = 0;
   int errors  = 0;

   // Reference model: fetch address, buffered {pc,instr} pairs, in-flight flags.
   logic [31:0] qPc[$];
   logic [31:0] qInstr[$];
   logic [31:0] mPc, mReqPc, mFetched, mRedirects;
   bit          mStarted, mOut, mDrop;

   // Memory environment.
   bit          memPend = 1'b0;
   int          memCnt = 0;
   int          memLat = 1;
   logic [31:0] memAddr = 32'h0;
   bit          opMix = 1'b0;
   logic [5:0]  opTable [8] = '{OP_RTYPE, OP_ADDI, OP_SW, OP_BGTZ, OP_J, OP_ADDI, OP_SW, OP_LW};

   function automatic logic [31:0] memWord(input logic [31:0] a);
      logic [31:0] w;
      w = a + 32'h0000_0100;
      if (opMix) w = {opTable[a[4:2]], w[25:0]};
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick(input bit doCheck);
      bit          expReq, expValid, fire, pop, accept, dutFire;
      logic [31:0] expInstr, expPc, dutAddr;
      @(negedge clk);
      expValid = (qPc.size() > 0);
      expInstr = expValid ? qInstr[0] : 32'h0;
      expPc    = expValid ? qPc[0] : 32'h0;
      expReq   = mStarted && !mOut && (qPc.size() < 2) && !redirect_valid;
      if (doCheck) begin
         check("model imem_req", {31'b0, imem_req}, {31'b0, expReq});
         check("model imem_addr", imem_addr, mPc);
         check("model instr_valid", {31'b0, instr_valid}, {31'b0, expValid});
         check("model instr", instr, expInstr);
         check("model instr_pc", instr_pc, expPc);
         check("model op", {26'b0, op}, {26'b0, expInstr[31:26]});
`ifdef IFETCH_PERF_EN
         check("model perf_fetched", perf_fetched, mFetched);
         check("model perf_redirects", perf_redirects, mRedirects);
`endif
      end
      dutFire = imem_req && imem_ready;
      dutAddr = imem_addr;
      @(posedge clk);
      fire   = expReq && imem_ready;
      pop    = expValid && instr_ready && !redirect_valid;
      accept = mOut && imem_rvalid;
      if (rst) begin
         mPc = 32'h0; mReqPc = 32'h0; qPc.delete(); qInstr.delete();
         mStarted = 1'b0; mOut = 1'b0; mDrop = 1'b0;
         mFetched = 32'h0; mRedirects = 32'h0;
      end else begin
         if (redirect_valid) begin
            qPc.delete(); qInstr.delete();
            mPc = redirect_pc & ~32'h3;
            mRedirects++;
            if (accept) begin
               mOut = 1'b0; mDrop = 1'b0;
            end else if (mOut) begin
               mDrop = 1'b1;
            end
         end else begin
            if (pop) begin
               void'(qPc.pop_front()); void'(qInstr.pop_front());
            end
            if (accept) begin
               if (!mDrop) begin
                  qPc.push_back(mReqPc); qInstr.push_back(imem_rdata); mFetched++;
               end
               mOut = 1'b0; mDrop = 1'b0;
            end
            if (fire) begin
               mReqPc = mPc; mPc = mPc + 32'd4; mOut = 1'b1;
            end
         end
         mStarted = 1'b1;
      end
      if (dutFire) begin
         memPend = 1'b1; memCnt = memLat; memAddr = dutAddr;
      end
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (memPend) begin
         memCnt--;
         if (memCnt == 0) begin
            imem_rvalid = 1'b1; imem_rdata = memWord(memAddr); memPend = 1'b0;
         end
      end
   endtask

   initial begin
      // Reset.
      tick(1'b0);
      tick(1'b1);
      rst = 1'b0; imem_ready = 1'b1; instr_ready = 1'b1;
      check("reset imem_req", {31'b0, imem_req}, 32'd0);
      check("reset imem_addr", imem_addr, 32'h0);
      check("reset instr_valid", {31'b0, instr_valid}, 32'd0);
      check("reset instr", instr, 32'h0);
      check("reset instr_pc", instr_pc, 32'h0);
      check("reset op", {26'b0, op}, 32'd0);
      // Streaming at one instruction per two cycles.
      repeat (3) tick(1'b1);
      check("first instr_pc", instr_pc, 32'h0);
      check("first instr", instr, 32'h100);
      repeat (2) tick(1'b1);
      check("second instr_pc", instr_pc, 32'h4);
      check("second instr", instr, 32'h104);
      check("third request addr", imem_addr, 32'h8);
      // Back-pressure from a fresh reset: two entries buffered, then no request.
      rst = 1'b1;
      tick(1'b1);
      rst = 1'b0; instr_ready = 1'b0;
      repeat (8) tick(1'b1);
      check("full imem_req", {31'b0, imem_req}, 32'd0);
      check("full head pc", instr_pc, 32'h0);
      check("full head instr", instr, 32'h100);
      instr_ready = 1'b1;
      tick(1'b1);
      check("pop order pc", instr_pc, 32'h4);
      check("resume addr", imem_addr, 32'h8);
      check("resume imem_req", {31'b0, imem_req}, 32'd1);
      // Redirect while waiting on 0x8: response dropped, buffer flushed.
      instr_ready = 1'b0; memLat = 2;
      tick(1'b1);
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick(1'b1);
      redirect_valid = 1'b0;
      check("flush instr_valid", {31'b0, instr_valid}, 32'd0);
      tick(1'b1);
      check("redirect addr", imem_addr, 32'h40);
      check("redirect imem_req", {31'b0, imem_req}, 32'd1);
      memLat = 1; instr_ready = 1'b1;
      repeat (2) tick(1'b1);
      check("redirected instr_pc", instr_pc, 32'h40);
      check("redirected instr", instr, 32'h140);
      // Redirect coinciding with rvalid, unaligned target.
      tick(1'b1);
      redirect_valid = 1'b1; redirect_pc = 32'h43;
      tick(1'b1);
      redirect_valid = 1'b0;
      check("rvalid redirect addr", imem_addr, 32'h40);
      check("rvalid redirect valid", {31'b0, instr_valid}, 32'd0);
      // Memory stall: request and address held.
      imem_ready = 1'b0;
      repeat (5) tick(1'b1);
      check("stall imem_req", {31'b0, imem_req}, 32'd1);
      check("stall imem_addr", imem_addr, 32'h40);
      check("stall instr_valid", {31'b0, instr_valid}, 32'd0);
      // PC wrap at the top of the address space.
      imem_ready = 1'b1; opMix = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick(1'b1);
      redirect_valid = 1'b0;
      check("wrap request addr", imem_addr, 32'hFFFF_FFFC);
      tick(1'b1);
      check("wrapped fetch addr", imem_addr, 32'h0);
      tick(1'b1);
      check("wrap instr_pc", instr_pc, 32'hFFFF_FFFC);
      check("wrap instr", instr, 32'h8C00_00FC);
      check("wrap op", {26'b0, op}, {26'b0, OP_LW});
      // Reset while waiting, late response lands in IDLE.
      memLat = 2;
      tick(1'b1);
      rst = 1'b1;
      tick(1'b1);
      rst = 1'b0; memLat = 1;
      check("late rvalid present", {31'b0, imem_rvalid}, 32'd1);
      check("post-rst instr_valid", {31'b0, instr_valid}, 32'd0);
      check("post-rst imem_req", {31'b0, imem_req}, 32'd0);
      check("post-rst imem_addr", imem_addr, 32'h0);
`ifdef IFETCH_PERF_EN
      check("post-rst perf_fetched", perf_fetched, 32'h0);
      check("post-rst perf_redirects", perf_redirects, 32'h0);
`endif
      tick(1'b1);
      check("restart imem_req", {31'b0, imem_req}, 32'd1);
      check("restart instr_valid", {31'b0, instr_valid}, 32'd0);
      // Mixed traffic: stalls, back-pressure, back-to-back redirects.
      for (int i = 0; i < 60; i++) begin
         instr_ready    = (i % 4 != 3);
         imem_ready     = (i % 7 != 2);
         memLat         = (i % 3 == 0) ? 2 : 1;
         redirect_valid = (i % 13 == 5) || (i % 13 == 6);
         redirect_pc    = 32'h200 + i * 8 + (i % 4);
         tick(1'b1);
      end
      redirect_valid = 1'b0;
      repeat (4) tick(1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
